// File: rtl/arbitro_cuenta_pkg.sv
// Shared types and defaults for the shared-account arbiter (arbitro_cuenta).
package cajero_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } estado_t;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  localparam int N_TERM_DEF  = 4;
  localparam int BAL_W_DEF   = 64;
  localparam int MONTO_W_DEF = 32;

endpackage

// File: rtl/arbitro_cuenta_if.sv
// Terminal-side request/response bundle of the shared-account arbiter.
interface arbitro_cuenta_if
  import cajero_pkg::*;
#(
  parameter int N_TERM  = N_TERM_DEF,
  parameter int BAL_W   = BAL_W_DEF,
  parameter int MONTO_W = MONTO_W_DEF
);

  logic                      CARGAR_BALANCE;
  logic [BAL_W-1:0]          BALANCE_INICIAL;
  logic [N_TERM-1:0]         REQ;
  logic [N_TERM-1:0]         TIPO_TRANS;
  logic [N_TERM*MONTO_W-1:0] MONTO;
  logic [N_TERM-1:0]         GNT;
  logic                      DONE_STB;
  logic                      ENTREGAR_DINERO;
  logic                      FONDOS_INSUFICIENTES;
  logic [BAL_W-1:0]          BALANCE_ACTUALIZADO;
  logic                      OCUPADO;

  modport master (
    output CARGAR_BALANCE, BALANCE_INICIAL, REQ, TIPO_TRANS, MONTO,
    input  GNT, DONE_STB, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           BALANCE_ACTUALIZADO, OCUPADO
  );

  modport slave (
    input  CARGAR_BALANCE, BALANCE_INICIAL, REQ, TIPO_TRANS, MONTO,
    output GNT, DONE_STB, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           BALANCE_ACTUALIZADO, OCUPADO
  );

endinterface

// File: rtl/arbitro_cuenta_selector_rr.sv
// Combinational requester selector: first set REQ bit at or after ptr_i wins.
// With ptr_i held at zero it degenerates to lowest-index fixed priority.
module selector_rr
  import cajero_pkg::*;
#(
  parameter int N_TERM = N_TERM_DEF,
  parameter int IDX_W  = 2
)(
  input  logic [N_TERM-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [N_TERM-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  always_comb begin
    int j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 0; off < N_TERM; off++) begin
      j = int'(ptr_i) + off;
      if (j >= N_TERM) j = j - N_TERM;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/arbitro_cuenta.sv
// Shared-account transaction arbiter: one terminal served per 4-cycle slot.
// Define ARBITRO_RR_EN for round-robin; otherwise lowest index always wins.
module arbitro_cuenta
  import cajero_pkg::*;
#(
  parameter int N_TERM  = N_TERM_DEF,
  parameter int BAL_W   = BAL_W_DEF,
  parameter int MONTO_W = MONTO_W_DEF
)(
  input  logic              CLK,
  input  logic              RESET,
  arbitro_cuenta_if.slave   bus
);

  localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;

  estado_t            state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr, winIdx;
  logic [N_TERM-1:0]  winOh, gnt;
  logic               winValid;
  logic               tipo_q, tipo_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic [BAL_W-1:0]   bal_q, bal_d, nb_q, nb_d, montoExt;
  logic [BAL_W:0]     suma;
  logic               ent_q, ent_d, fon_q, fon_d;
  logic               done, entOut, fonOut;

  selector_rr #(.N_TERM(N_TERM), .IDX_W(IDX_W)) u_sel (
    .req_i   (bus.REQ),
    .ptr_i   (ptr),
    .gnt_o   (winOh),
    .idx_o   (winIdx),
    .valid_o (winValid)
  );

  assign montoExt = BAL_W'(monto_q);
  assign suma     = {1'b0, bal_q} + {1'b0, montoExt};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tipo_d  = tipo_q;
    monto_d = monto_q;
    bal_d   = bal_q;
    nb_d    = nb_q;
    ent_d   = ent_q;
    fon_d   = fon_q;
    gnt     = '0;
    done    = 1'b0;
    entOut  = 1'b0;
    fonOut  = 1'b0;
    if (state_q != IDLE) gnt[idx_q] = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.CARGAR_BALANCE) begin
          bal_d = bus.BALANCE_INICIAL;
        end else if (winValid) begin
          idx_d   = winIdx;
          tipo_d  = |(bus.TIPO_TRANS & winOh);
          monto_d = bus.MONTO[winIdx*MONTO_W +: MONTO_W];
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Outcome is decided here and only committed on the EXEC edge,
        // so a reset during EXEC leaves the balance untouched.
        if (tipo_q == TIPO_RETIRO) begin
          if (montoExt <= bal_q) begin
            nb_d  = bal_q - montoExt;
            ent_d = 1'b1;
            fon_d = 1'b0;
          end else begin
            nb_d  = bal_q;
            ent_d = 1'b0;
            fon_d = 1'b1;
          end
        end else begin
          nb_d  = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
          ent_d = 1'b0;
          fon_d = 1'b0;
        end
        state_d = EXEC;
      end
      EXEC: begin
        bal_d   = nb_q;
        state_d = RESP;
      end
      RESP: begin
        done    = 1'b1;
        entOut  = ent_q;
        fonOut  = fon_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tipo_q  <= 1'b0;
      monto_q <= '0;
      bal_q   <= '0;
      nb_q    <= '0;
      ent_q   <= 1'b0;
      fon_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tipo_q  <= tipo_d;
      monto_q <= monto_d;
      bal_q   <= bal_d;
      nb_q    <= nb_d;
      ent_q   <= ent_d;
      fon_q   <= fon_d;
    end
  end

`ifdef ARBITRO_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP)
      ptr_d = (idx_q == IDX_W'(N_TERM - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign bus.GNT                  = gnt;
  assign bus.DONE_STB             = done;
  assign bus.ENTREGAR_DINERO      = entOut;
  assign bus.FONDOS_INSUFICIENTES = fonOut;
  assign bus.BALANCE_ACTUALIZADO  = bal_q;
  assign bus.OCUPADO              = (state_q != IDLE);

endmodule

// File: tb/tb_arbitro_cuenta.sv
// Self-checking bench for arbitro_cuenta: directed scenarios plus random traffic
// checked against an arithmetic account model (honours ARBITRO_RR_EN).
module tb_arbitro_cuenta;
  import cajero_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  longint unsigned balM;
  int              ptrM;

  logic [3:0]   pend, tipoR;
  logic [127:0] montoR;
  logic [63:0]  v;
  int           w;

  arbitro_cuenta_if #(.N_TERM(N), .BAL_W(64), .MONTO_W(32)) bus ();

  arbitro_cuenta #(.N_TERM(N), .BAL_W(64), .MONTO_W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] tipo,
                               input logic [127:0] monto);
    bus.REQ        = req;
    bus.TIPO_TRANS = tipo;
    bus.MONTO      = monto;
  endtask

  function automatic logic [127:0] packM(input int t, input logic [31:0] m);
    logic [127:0] r;
    r = '0;
    r[t*32 +: 32] = m;
    return r;
  endfunction

  function automatic int pickWinner(input logic [3:0] req, input int ptr);
`ifdef ARBITRO_RR_EN
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int k = 0; k < N; k++)
      if (req[k]) return k;
`endif
    return 0;
  endfunction

  task automatic modelApply(input logic tipo, input longint unsigned m,
                            output logic ent, output logic fon);
    ent = 1'b0;
    fon = 1'b0;
    if (tipo == TIPO_DEPOSITO) begin
      if (balM > 64'hFFFF_FFFF_FFFF_FFFF - m) balM = 64'hFFFF_FFFF_FFFF_FFFF;
      else balM = balM + m;
    end else if (m <= balM) begin
      balM = balM - m;
      ent  = 1'b1;
    end else begin
      fon = 1'b1;
    end
  endtask

  task automatic loadBal(input logic [63:0] val, input logic [3:0] req);
    bus.CARGAR_BALANCE  = 1'b1;
    bus.BALANCE_INICIAL = val;
    bus.REQ             = req;
    tick();
    balM = val;
    checkOutput("load bal", bus.BALANCE_ACTUALIZADO, 64'(balM));
    checkOutput("load gnt", 64'(bus.GNT), 64'(0));
    checkOutput("load ocupado", 64'(bus.OCUPADO), 64'(0));
    bus.CARGAR_BALANCE = 1'b0;
  endtask

  // Starts in IDLE, ends one cycle after the completion strobe (back in IDLE).
  task automatic serveOne(input string tag, input logic [3:0] req, input logic [3:0] tipo,
                          input logic [127:0] monto, input bit dropReq, output int wOut);
    int              wi;
    logic            ent, fon;
    logic [3:0]      oh;
    longint unsigned prevBal;
    wi      = pickWinner(req, ptrM);
    oh      = 4'(4'b0001 << wi);
    prevBal = balM;
    modelApply(tipo[wi], 64'(monto[wi*32 +: 32]), ent, fon);
    applyStimulus(req, tipo, monto);
    tick();
    checkOutput({tag, " gnt"}, 64'(bus.GNT), 64'(oh));
    checkOutput({tag, " ocupado"}, 64'(bus.OCUPADO), 64'(1));
    checkOutput({tag, " early done"}, 64'(bus.DONE_STB), 64'(0));
    bus.MONTO      = {$urandom, $urandom, $urandom, $urandom};
    bus.TIPO_TRANS = 4'($urandom);
    tick();
    checkOutput({tag, " exec gnt"}, 64'(bus.GNT), 64'(oh));
    checkOutput({tag, " exec bal"}, bus.BALANCE_ACTUALIZADO, 64'(prevBal));
    tick();
    checkOutput({tag, " done"}, 64'(bus.DONE_STB), 64'(1));
    checkOutput({tag, " resp gnt"}, 64'(bus.GNT), 64'(oh));
    checkOutput({tag, " entregar"}, 64'(bus.ENTREGAR_DINERO), 64'(ent));
    checkOutput({tag, " fondos"}, 64'(bus.FONDOS_INSUFICIENTES), 64'(fon));
    checkOutput({tag, " bal"}, bus.BALANCE_ACTUALIZADO, 64'(balM));
    applyStimulus(req, tipo, monto);
    if (dropReq) bus.REQ[wi] = 1'b0;
    tick();
    checkOutput({tag, " idle done"}, 64'(bus.DONE_STB), 64'(0));
    checkOutput({tag, " idle gnt"}, 64'(bus.GNT), 64'(0));
    checkOutput({tag, " idle ocupado"}, 64'(bus.OCUPADO), 64'(0));
    ptrM = (wi + 1) % N;
    wOut = wi;
  endtask

  initial begin
    rst = 1'b1;
    bus.CARGAR_BALANCE  = 1'b0;
    bus.BALANCE_INICIAL = '0;
    applyStimulus(4'b0000, 4'b0000, '0);
    balM = 0;
    ptrM = 0;
    tick();
    tick();
    checkOutput("rst gnt", 64'(bus.GNT), 64'(0));
    checkOutput("rst done", 64'(bus.DONE_STB), 64'(0));
    checkOutput("rst entregar", 64'(bus.ENTREGAR_DINERO), 64'(0));
    checkOutput("rst fondos", 64'(bus.FONDOS_INSUFICIENTES), 64'(0));
    checkOutput("rst bal", bus.BALANCE_ACTUALIZADO, 64'(0));
    checkOutput("rst ocupado", 64'(bus.OCUPADO), 64'(0));
    rst = 1'b0;

    loadBal(64'd1000, 4'b0000);
    serveOne("dep250", 4'b0001, 4'b0000, packM(0, 32'd250), 1'b1, w);

    loadBal(64'd1000, 4'b0000);
    serveOne("ret1000", 4'b0100, 4'b0100, packM(2, 32'd1000), 1'b1, w);
    serveOne("ret1", 4'b0100, 4'b0100, packM(2, 32'd1), 1'b1, w);

    loadBal(64'hFFFF_FFFF_FFFF_FFF6, 4'b0000);
    serveOne("sat", 4'b1000, 4'b0000, packM(3, 32'd100), 1'b1, w);

    bus.TIPO_TRANS = 4'b0000;
    bus.MONTO      = packM(1, 32'd40);
    loadBal(64'd500, 4'b0010);
    serveOne("load+req1", 4'b0010, 4'b0000, packM(1, 32'd40), 1'b1, w);

    loadBal(64'd1000, 4'b0000);
    applyStimulus(4'b0001, 4'b0001, packM(0, 32'd300));
    tick();
    checkOutput("abort gnt", 64'(bus.GNT), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.REQ = 4'b0000;
    balM = 0;
    ptrM = 0;
    checkOutput("abort gnt0", 64'(bus.GNT), 64'(0));
    checkOutput("abort bal", bus.BALANCE_ACTUALIZADO, 64'(0));
    checkOutput("abort ocupado", 64'(bus.OCUPADO), 64'(0));
    for (int i = 0; i < 4; i++) begin
      checkOutput("abort no done", 64'(bus.DONE_STB), 64'(0));
      tick();
    end

    for (int r = 0; r < 5; r++)
      serveOne("held", 4'b1111, 4'b0000, {4{32'd1}}, 1'b0, w);
    bus.REQ = 4'b0000;

    pend   = 4'b0000;
    tipoR  = 4'b0000;
    montoR = '0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          tipoR[i] = 1'($urandom_range(0, 1));
          montoR[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2500));
        end
      end
      if (pend == 4'b0000) begin
        pend[0]  = 1'b1;
        tipoR[0] = TIPO_DEPOSITO;
        montoR[31:0] = 32'($urandom_range(1, 900));
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       v = 64'($urandom_range(0, 3000));
          1:       v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 500));
          default: v = {$urandom, $urandom};
        endcase
        bus.TIPO_TRANS = tipoR;
        bus.MONTO      = montoR;
        loadBal(v, pend);
      end
      serveOne("rnd", pend, tipoR, montoR, 1'b1, w);
      pend[w] = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/arbitro_cuenta.md
# arbitro_cuenta

Shared-account transaction arbiter: up to N_TERM cajero front-ends (PIN/session handling already complete) post deposit or withdrawal requests against a single account balance register. The block selects one requester at a time, applies the transaction to the balance, and returns a one-cycle completion strobe with the outcome. It sits between the per-terminal `Cajero` instances and the account storage, replacing each terminal's private `BALANCE_INICIAL`/`BALANCE_ACTUALIZADO` path.

## Interface
- N_TERM, 4, number of requesting terminals (2..8)
- BAL_W, 64, balance width
- MONTO_W, 32, per-request amount width
- CLK  input  1  single clock, all logic on rising edge
- RESET  input  1  synchronous, active-high
- CARGAR_BALANCE  input  1  load BALANCE_INICIAL into the balance register
- BALANCE_INICIAL  input  BAL_W  value to load
- REQ  input  N_TERM  per-terminal request, level, held until served
- TIPO_TRANS  input  N_TERM  per-terminal type: 0 = deposit, 1 = withdrawal
- MONTO  input  N_TERM*MONTO_W  flattened amounts, terminal i at [i*MONTO_W +: MONTO_W]
- GNT  output  N_TERM  one-hot grant, zero when idle
- DONE_STB  output  1  one-cycle completion strobe, qualified by GNT
- ENTREGAR_DINERO  output  1  withdrawal accepted (valid with DONE_STB)
- FONDOS_INSUFICIENTES  output  1  withdrawal rejected (valid with DONE_STB)
- BALANCE_ACTUALIZADO  output  BAL_W  current balance register
- OCUPADO  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, GRANT, EXEC, RESP.
- IDLE: if CARGAR_BALANCE, load balance, stay IDLE, issue no grant (load beats REQ). Else if REQ != 0, select winner, latch index, TIPO_TRANS and MONTO of winner, go GRANT.
- GRANT: GNT[winner]=1; evaluate; go EXEC.
- EXEC: write balance; latch outcome flags; go RESP.
- RESP: GNT[winner]=1, DONE_STB=1, outcome flags driven; advance priority pointer to winner+1 mod N_TERM; go IDLE.
- Deposit: balance + zero-extended MONTO, saturating at all-ones; ENTREGAR_DINERO=0, FONDOS_INSUFICIENTES=0.
- Withdrawal: MONTO <= balance -> balance - MONTO, ENTREGAR_DINERO=1; MONTO > balance -> balance unchanged, FONDOS_INSUFICIENTES=1. MONTO equal to balance is accepted (balance 0).
- Flags are 0 outside RESP.
- CARGAR_BALANCE outside IDLE: ignored.
- REQ changes after the IDLE sampling edge do not affect the in-flight transaction (latched values used).
- RESET at any state: abort in-flight transaction without writing balance; next cycle all outputs at reset values.

## Timing
- Reset values: GNT=0, DONE_STB=0, ENTREGAR_DINERO=0, FONDOS_INSUFICIENTES=0, BALANCE_ACTUALIZADO=0, OCUPADO=0, state IDLE, pointer 0.
- REQ sampled high in IDLE at edge k: GNT visible after k, BALANCE_ACTUALIZADO updated after k+2, DONE_STB high for cycle between k+2 and k+3, IDLE after k+3. Service time 3 cycles; back-to-back grants every 4 cycles.
- Requester rule: drop REQ[i] at the edge ending its DONE_STB cycle (registered response is sufficient); REQ still high at next IDLE sample is a new request.
- Load: CARGAR_BALANCE high in IDLE at edge k -> BALANCE_ACTUALIZADO = BALANCE_INICIAL after k.

## Configuration
- ARBITRO_RR_EN defined: round-robin; search starts at pointer, first REQ bit found wins.
- ARBITRO_RR_EN undefined: fixed priority, lowest index wins, pointer logic removed.

## Structure
- Package `cajero_pkg`: FSM state enum, TIPO_DEPOSITO/TIPO_RETIRO constants, default BAL_W/MONTO_W.
- Sub-module `selector_rr`: combinational; REQ vector + pointer -> one-hot winner and index; fixed-priority when pointer tied to 0.

## Test plan
- RESET, load 1000, REQ[0] deposit 250 -> DONE_STB with GNT=0001 at cycle 3, balance 1250, both flags 0.
- Balance 1000, REQ[2] withdrawal 1000 -> ENTREGAR_DINERO=1, balance 0; repeat with 1 -> FONDOS_INSUFICIENTES=1, balance stays 0.
- REQ=1111 held, all deposit 1 (ARBITRO_RR_EN) -> grants 0001, 0010, 0100, 1000, 0001 each 4 cycles apart; without macro -> 0001 until REQ[0] drops.
- Balance 2^64-10, deposit 100 -> balance 2^64-1.
- CARGAR_BALANCE and REQ[1] same IDLE cycle -> load 500 applied, no grant; REQ[1] granted next cycle.
- RESET asserted during EXEC of withdrawal 300 from 1000 -> next cycle GNT=0, DONE_STB never pulses, balance 0.
